fpu_sequencer: RTL and testbench

Upstream feeder for the floating-point adder, including result capture. It queues operand pairs in a small FIFO and presents one pair at a time on stable, registered operand lines. It holds each pair for a fixed settle window that covers the adder's worst-case normalisation loop, then samples the adder's result and status into an output register with a valid/ready handshake. This gives the adder, which has no handshake of its own, a clean transaction interface toward the rest of the design.

---
 rtl/fpu_sequencer.sv | 158 +++++++++++++++
 tb/tb_fpu_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sequencer.sv
// rtl/fpu_sequencer.sv - operand FIFO, fixed settle window and result capture around the FP adder
//
// Queues operand pairs, presents one pair at a time on registered operand
// lines, holds it for HOLD_CYCLES cycles so the adder can settle, then
// captures the adder result/status into a valid/ready output register.
//
// Optional feature macro: FPU_SEQ_STICKY_EN (accumulates captured status bits).
//
// Ports:
//   clock100KHz              sole clock, rising edge
//   reset                    synchronous, active-high
//   in_valid/in_ready        operand pair handshake (in_ready = FIFO not full)
//   in_a, in_b               operand pair to enqueue
//   op_A_out, op_B_out       registered operands driven to the adder
//   fpu_data_in              adder result
//   fpu_status_in            adder status, one-hot
//   out_valid/out_ready      captured result handshake
//   out_data, out_status     captured result and status
//   busy                     state machine is not idle
//   fifo_count               occupied FIFO entries
//   sticky_status            OR of captured statuses (0 when feature disabled)
//   clear_sticky             clears sticky_status (ignored when feature disabled)
module fpu_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                     clock100KHz,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic [31:0]              op_A_out,
  output logic [31:0]              op_B_out,
  input  logic [31:0]              fpu_data_in,
  input  logic [3:0]               fpu_status_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [3:0]               out_status,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [3:0]               sticky_status,
  input  logic                     clear_sticky
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [CW-1:0] HOLD_ONE = 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_CAPTURE, S_OUT_WAIT} state_t;

  state_t          state;
  logic [CW-1:0]   hold_cnt;
  logic [31:0]     mem_a [DEPTH];
  logic [31:0]     mem_b [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;

  // DEPTH is a power of two, so count < DEPTH exactly when the MSB is clear.
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign in_ready   = ~count[AW];
  assign push       = in_valid && in_ready;
  assign pop        = (state == S_IDLE) && (count != '0);
  assign fifo_count = count;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_a[wr_ptr] <= in_a;
        mem_b[wr_ptr] <= in_b;
        wr_ptr        <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      op_A_out   <= '0;
      op_B_out   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            op_A_out <= mem_a[rd_ptr];
            op_B_out <= mem_b[rd_ptr];
            hold_cnt <= '0;
            state    <= S_HOLD;
          end
        end
        S_HOLD: begin
          // Counter saturates at HOLD_CYCLES at most, so its width never wraps.
          hold_cnt <= hold_cnt + HOLD_ONE;
          if (hold_cnt == HOLD_LAST) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          out_data   <= fpu_data_in;
          out_status <= fpu_status_in;
          out_valid  <= 1'b1;
          state      <= S_OUT_WAIT;
        end
        S_OUT_WAIT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FPU_SEQ_STICKY_EN
  // Clear wins over a same-cycle accumulate.
  always_ff @(posedge clock100KHz) begin
    if (reset || clear_sticky) begin
      sticky_status <= '0;
    end else if (state == S_CAPTURE) begin
      sticky_status <= sticky_status | fpu_status_in;
    end
  end
`else
  logic unused_clear_sticky;
  assign unused_clear_sticky = clear_sticky;
  assign sticky_status       = 4'b0000;
`endif

endmodule

// File: tb/tb_fpu_sequencer.sv
// tb/tb_fpu_sequencer.sv - directed table-driven bench for fpu_sequencer with an adder stub
module tb_fpu_sequencer;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic [31:0] fpu_data_in;
  logic [3:0]  fpu_status_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [3:0]  sticky_status;
  logic        clear_sticky;

  // Adder stub: either a fixed result, or echo of operand A to tag results.
  logic        echo;
  logic [31:0] stub_data;
  logic [3:0]  stub_status;
  assign fpu_data_in   = echo ? op_A_out : stub_data;
  assign fpu_status_in = stub_status;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clock100KHz  (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .op_A_out     (op_A_out),
    .op_B_out     (op_B_out),
    .fpu_data_in  (fpu_data_in),
    .fpu_status_in(fpu_status_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_status   (out_status),
    .busy         (busy),
    .fifo_count   (fifo_count),
    .sticky_status(sticky_status),
    .clear_sticky (clear_sticky)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  st;
    logic [31:0] exp_data;
    logic [3:0]  exp_status;
  } vec_t;

  vec_t vecs [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_out(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  // One transaction from an idle, empty sequencer, with latency checks.
  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic [3:0] st,
                     input logic [31:0] ed, input logic [3:0] es);
    stub_data   = res;
    stub_status = st;
    in_a        = a;
    in_b        = b;
    in_valid    = 1'b1;
    tick;                      // E0: push
    in_valid = 1'b0;
    tick;                      // E1: pop into operand registers
    chk({tag, "_op_a"}, op_A_out, a);
    chk({tag, "_op_b"}, op_B_out, b);
    repeat (HOLD) tick;        // after E(HOLD+1)
    chk({tag, "_valid_early"}, 32'(out_valid), 32'd0);
    tick;                      // after E(HOLD+2)
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, out_data, ed);
    chk({tag, "_status"}, 32'(out_status), 32'(es));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk({tag, "_valid_clr"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    bit ok;
    int acc;
    int got;
    int next_push;
    int bad;

    vecs[0] = '{32'h41000000, 32'h40800000, 32'h41400000, 4'b0001, 32'h41400000, 4'b0001};
    vecs[1] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0001, 32'h40000000, 4'b0001};
    vecs[2] = '{32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 32'h7F800000, 4'b0100};
    vecs[3] = '{32'h00800000, 32'h80400000, 32'h00400000, 4'b1000, 32'h00400000, 4'b1000};
    vecs[4] = '{32'h3F800001, 32'h3F800000, 32'h40000000, 4'b0010, 32'h40000000, 4'b0010};

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
    echo         = 1'b0;
    stub_data    = '0;
    stub_status  = 4'b0001;
    tick;
    tick;
    reset = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sticky", 32'(sticky_status), 32'd0);

    // Reset in the middle of HOLD with another pair queued.
    in_valid = 1'b1;
    in_a = 32'h12345678;
    in_b = 32'h9ABCDEF0;
    tick;
    in_a = 32'h0BADF00D;
    tick;
    in_valid = 1'b0;
    tick;
    do_reset;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_op_a", op_A_out, 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (20) tick;
    chk("mid_rst_no_result", 32'(out_valid), 32'd0);
    chk("mid_rst_still_idle", 32'(busy), 32'd0);

    // Table of single transactions.
    foreach (vecs[i]) begin
      txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].st,
          vecs[i].exp_data, vecs[i].exp_status);
    end

`ifdef FPU_SEQ_STICKY_EN
    do_reset;
    txn("stk0", 32'h3F800001, 32'h3F800000, 32'h40000000, 4'b0010, 32'h40000000, 4'b0010);
    txn("stk1", 32'h00800000, 32'h80400000, 32'h00400000, 4'b1000, 32'h00400000, 4'b1000);
    chk("sticky_or", 32'(sticky_status), 32'h0000000A);
    clear_sticky = 1'b1;
    tick;
    clear_sticky = 1'b0;
    chk("sticky_clear", 32'(sticky_status), 32'd0);
`else
    chk("sticky_off", 32'(sticky_status), 32'd0);
`endif

    // Full FIFO with the output stalled.
    do_reset;
    echo = 1'b1;
    stub_status = 4'b0001;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_a = 32'h101 + 32'(i);
      in_b = 32'h0;
      if (in_ready) acc++;
      tick;
    end
    in_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(fifo_count), 32'd4);
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid) begin
        if (got < 5) chk($sformatf("full_order%0d", got), out_data, 32'h101 + 32'(got));
        got++;
      end
      tick;
    end
    out_ready = 1'b0;
    chk("full_drained", 32'(got), 32'd5);

    // Ordering across pointer wrap with random backpressure.
    do_reset;
    got = 0;
    next_push = 0;
    for (int c = 0; c < 1000 && got < 10; c++) begin
      in_valid  = (next_push < 10);
      in_a      = 32'(next_push + 1);
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) next_push++;
      if (out_valid && out_ready) begin
        chk($sformatf("wrap_order%0d", got), out_data, 32'(got + 1));
        got++;
      end
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("wrap_count", 32'(got), 32'd10);
    repeat (20) tick;
    chk("wrap_no_extra", 32'(out_valid), 32'd0);
    chk("wrap_empty", 32'(fifo_count), 32'd0);

    // Backpressure: output must stay frozen while out_ready is low.
    do_reset;
    echo = 1'b0;
    stub_data = 32'hCAFE0001;
    stub_status = 4'b0010;
    in_valid = 1'b1;
    in_a = 32'h11;
    tick;
    in_a = 32'h22;
    tick;
    in_valid = 1'b0;
    wait_out(50, ok);
    chk("bp_timeout", 32'(ok), 32'd1);
    stub_data = 32'hDEAD0000;
    stub_status = 4'b0100;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!out_valid || out_data !== 32'hCAFE0001 || out_status !== 4'b0010 ||
          op_A_out !== 32'h11 || fifo_count !== 3'd1) bad++;
      tick;
    end
    chk("bp_stable_cycles_bad", 32'(bad), 32'd0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    tick;
    chk("bp_next_pop", op_A_out, 32'h22);
    chk("bp_next_count", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
